// File: rtl/chebyshev_recurrence_pkg.sv
// Shared definitions for the Chebyshev term generator: FSM encodings and
// the fixed-point one-constant helper.
package chebyshev_recurrence_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EMIT    = 2'd1,
      ST_COMPUTE = 2'd2
   } state_t;

   // 1.0 in a format with frac fraction bits; callers cast to their word length
   function automatic logic [63:0] fxp_one(input int frac);
      return 64'd1 << frac;
   endfunction

endpackage

// File: rtl/chebyshev_fxp_mul.sv
// Combinational doubled fixed-point product: wrap(((a*b) << 1) >>> FRAC).
// The shift truncates toward minus infinity; the result wraps to WL bits.
module chebyshev_fxp_mul #(
   parameter int WL   = 16,
   parameter int FRAC = 12
) (
   input  logic [WL-1:0] a,
   input  logic [WL-1:0] b,
   output logic [WL-1:0] y
);

   logic signed [2*WL-1:0] a_ext;
   logic signed [2*WL-1:0] b_ext;
   logic signed [2*WL-1:0] prod;

   assign a_ext = {{WL{a[WL-1]}}, a};
   assign b_ext = {{WL{b[WL-1]}}, b};
   assign prod  = a_ext * b_ext;

   // Doubling then shifting by FRAC equals taking bits [WL+FRAC-2 : FRAC-1]
   assign y = WL'(prod >>> (FRAC - 1));

endmodule

// File: rtl/chebyshev_recurrence.sv
// Sequential generator of T_0(x)..T_N(x) via T_k = 2x*T_{k-1} - T_{k-2},
// emitting one unsaturated WL-bit term per valid/ready handshake.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start; no term presented
// ST_EMIT    | term T_k presented on out_data, held until handshake
// ST_COMPUTE | one-cycle step computing T_{k+1}, out_valid low
module chebyshev_recurrence
   import chebyshev_recurrence_pkg::*;
#(
   parameter int WL     = 16,
   parameter int I_BITS = 4,
   parameter int N_MAX  = 15,
   localparam int OW    = $clog2(N_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [WL-1:0] x_in,
   input  logic [OW-1:0] order_in,
   output logic          busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WL-1:0] out_data,
   output logic [OW-1:0] out_index,
   output logic          out_last
);

   localparam int            FRAC  = WL - I_BITS;
   localparam logic [WL-1:0] ONE   = WL'(fxp_one(FRAC));
   localparam logic [OW-1:0] N_CAP = OW'(N_MAX);

   state_t        state;
   state_t        state_next;

   logic [WL-1:0] x_reg;
   logic [WL-1:0] t_km1;
   logic [WL-1:0] t_km2;
   logic [WL-1:0] mul_y;
   logic [WL-1:0] term;
   logic [OW-1:0] k;
   logic [OW-1:0] k_next;
   logic [OW-1:0] n_reg;
   logic [OW-1:0] order_clamped;
   logic          load;
   logic          advance;
   logic          handshake;
   logic          at_last;

   assign order_clamped = (order_in > N_CAP) ? N_CAP : order_in;
   assign load          = (state == ST_IDLE) && start;
   assign advance       = (state == ST_COMPUTE);
   assign handshake     = (state == ST_EMIT) && out_ready;
   assign at_last       = (k == n_reg);
   assign k_next        = k + 1'b1;
   assign out_index     = k;

   chebyshev_fxp_mul #(
      .WL   (WL),
      .FRAC (FRAC)
   ) u_mul (
      .a (x_reg),
      .b (t_km1),
      .y (mul_y)
   );

   // T_1 is x itself; later terms subtract T_{k-2} with natural wraparound
   assign term = (k == '0) ? x_reg : (mul_y - t_km2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (handshake) begin
               state_next = at_last ? ST_IDLE : ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            state_next = ST_EMIT;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         x_reg     <= '0;
         t_km1     <= '0;
         t_km2     <= '0;
         k         <= '0;
         n_reg     <= '0;
      end else begin
         busy      <= (state_next != ST_IDLE);
         out_valid <= (state_next == ST_EMIT);
         if (load) begin
            x_reg    <= x_in;
            n_reg    <= order_clamped;
            k        <= '0;
            t_km1    <= ONE;
            t_km2    <= '0;
            out_data <= ONE;
            out_last <= (order_clamped == '0);
         end else if (advance) begin
            k        <= k_next;
            t_km2    <= t_km1;
            t_km1    <= term;
            out_data <= term;
            out_last <= (k_next == n_reg);
         end
      end
   end

endmodule

// File: tb/tb_chebyshev_recurrence.sv
// Self-checking bench for chebyshev_recurrence: table vectors, model-driven
// random vectors and hand-written backpressure/reset/clamp sequences.
module tb_chebyshev_recurrence;

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  idx;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic [15:0]      x;
      logic [3:0]       n;
      logic [5:0][15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] x_in;
   logic [3:0]  order_in;
   logic        out_ready;
   logic        sel_b;

   logic        busy_a, valid_a, last_a;
   logic [15:0] data_a;
   logic [3:0]  idx_a;
   logic        busy_b, valid_b, last_b;
   logic [15:0] data_b;
   logic [2:0]  idx_b;
   logic        start_a, start_b;

   logic        busy_m, valid_m, last_m;
   logic [15:0] data_m;
   logic [3:0]  idx_m;

   exp_t sb[$];
   vec_t tab[6];
   int   tests  = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign start_a = start & ~sel_b;
   assign start_b = start & sel_b;
   assign busy_m  = sel_b ? busy_b  : busy_a;
   assign valid_m = sel_b ? valid_b : valid_a;
   assign last_m  = sel_b ? last_b  : last_a;
   assign data_m  = sel_b ? data_b  : data_a;
   assign idx_m   = sel_b ? {1'b0, idx_b} : idx_a;

   chebyshev_recurrence #(.WL(16), .I_BITS(4), .N_MAX(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_a),
      .x_in      (x_in),
      .order_in  (order_in),
      .busy      (busy_a),
      .out_valid (valid_a),
      .out_ready (out_ready),
      .out_data  (data_a),
      .out_index (idx_a),
      .out_last  (last_a)
   );

   chebyshev_recurrence #(.WL(16), .I_BITS(4), .N_MAX(5)) dut5 (
      .clk       (clk),
      .rst       (rst),
      .start     (start_b),
      .x_in      (x_in),
      .order_in  (order_in[2:0]),
      .busy      (busy_b),
      .out_valid (valid_b),
      .out_ready (out_ready),
      .out_data  (data_b),
      .out_index (idx_b),
      .out_last  (last_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] x, input logic [3:0] n,
                               input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3,
                               input logic [15:0] e4, input logic [15:0] e5);
      vec_t v;
      v.x   = x;
      v.n   = n;
      v.exp = {e5, e4, e3, e2, e1, e0};
      return v;
   endfunction

   task automatic push_exp(input logic [15:0] d, input int k, input int n);
      exp_t e;
      e.data = d;
      e.idx  = 4'(k);
      e.last = (k == n);
      sb.push_back(e);
   endtask

   // Independent reference: 64-bit arithmetic, floor shift, wrap to 16 bits
   task automatic push_model(input logic [15:0] x, input int n);
      longint      sx, t1, t2, p, s, term;
      logic [15:0] w;
      sx = longint'($signed(x));
      t1 = 0;
      t2 = 0;
      for (int k = 0; k <= n; k++) begin
         if (k == 0) begin
            term = 4096;
         end else if (k == 1) begin
            term = sx;
         end else begin
            p    = sx * t1;
            s    = (p * 2) >>> 12;
            w    = 16'(s - t2);
            term = longint'($signed(w));
         end
         push_exp(16'(term), k, n);
         t2 = t1;
         t1 = term;
      end
   endtask

   task automatic do_start(input logic [15:0] x, input logic [3:0] n);
      start    = 1'b1;
      x_in     = x;
      order_in = n;
      @(negedge clk);
      start = 1'b0;
      chk("valid_latency1", 32'(valid_m), 32'd1);
      chk("busy_on_start", 32'(busy_m), 32'd1);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("out_data", 32'(data_m), 32'(e.data));
         chk("out_index", 32'(idx_m), 32'(e.idx));
         chk("out_last", 32'(last_m), 32'(e.last));
      end
   endtask

   task automatic consume(input int budget, input bit rnd);
      exp_t e;
      bit   done = 1'b0;
      int   cyc  = 0;
      while (!done && cyc < budget) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (valid_m && out_ready) begin
            if (sb.size() == 0) begin
               chk("scoreboard_nonempty", 32'd0, 32'd1);
               done = 1'b1;
            end else begin
               e = sb[0];
               pop_check();
               done = e.last;
            end
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      if (!done) chk("sequence_timeout", 32'd0, 32'd1);
      chk("busy_drop", 32'(busy_m), 32'd0);
      chk("valid_drop", 32'(valid_m), 32'd0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_busy"},  32'(busy_m),  32'd0);
      chk({name, "_valid"}, 32'(valid_m), 32'd0);
      chk({name, "_data"},  32'(data_m),  32'd0);
      chk({name, "_index"}, 32'(idx_m),   32'd0);
      chk({name, "_last"},  32'(last_m),  32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = mk(16'h0800, 4'd4, 16'h1000, 16'h0800, 16'hF800, 16'hF000, 16'hF800, 16'h0);
      tab[1] = mk(16'hF000, 4'd3, 16'h1000, 16'hF000, 16'h1000, 16'hF000, 16'h0, 16'h0);
      tab[2] = mk(16'h1000, 4'd3, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0, 16'h0);
      tab[3] = mk(16'h2000, 4'd3, 16'h1000, 16'h2000, 16'h7000, 16'hA000, 16'h0, 16'h0);
      tab[4] = mk(16'h0001, 4'd2, 16'h1000, 16'h0001, 16'hF000, 16'h0, 16'h0, 16'h0);
      tab[5] = mk(16'h1234, 4'd0, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

      rst       = 1'b1;
      start     = 1'b0;
      x_in      = '0;
      order_in  = '0;
      out_ready = 1'b0;
      sel_b     = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("post_reset");

      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k <= int'(tab[i].n); k++) push_exp(tab[i].exp[k], k, int'(tab[i].n));
         do_start(tab[i].x, tab[i].n);
         consume(200, i[0]);
      end

      for (int i = 0; i < 6; i++) begin
         logic [15:0] rx;
         logic [3:0]  rn;
         rx = 16'($urandom_range(0, 65535));
         rn = 4'($urandom_range(0, 15));
         push_model(rx, int'(rn));
         do_start(rx, rn);
         consume(500, 1'b1);
      end

      // Backpressure on T_1 with a start pulse while busy
      push_model(16'h0800, 4);
      do_start(16'h0800, 4'd4);
      out_ready = 1'b1;
      pop_check();
      @(negedge clk);
      out_ready = 1'b0;
      chk("compute_valid_low", 32'(valid_m), 32'd0);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(valid_m), 32'd1);
         chk("bp_data", 32'(data_m), 32'h0800);
         chk("bp_index", 32'(idx_m), 32'd1);
         start    = (c == 2);
         x_in     = 16'h2000;
         order_in = 4'd1;
         @(negedge clk);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      pop_check();
      @(negedge clk);
      out_ready = 1'b0;
      chk("hs_t1_valid", 32'(valid_m), 32'd0);
      @(negedge clk);
      chk("hs_t2_valid", 32'(valid_m), 32'd1);
      consume(200, 1'b0);

      // start held during the final handshake is taken one cycle later
      push_exp(16'h1000, 0, 0);
      do_start(16'h0800, 4'd0);
      out_ready = 1'b1;
      start     = 1'b1;
      x_in      = 16'hF000;
      order_in  = 4'd1;
      pop_check();
      @(negedge clk);
      chk("last_hs_busy", 32'(busy_m), 32'd0);
      chk("last_hs_valid", 32'(valid_m), 32'd0);
      push_model(16'hF000, 1);
      @(negedge clk);
      start = 1'b0;
      chk("restart_valid", 32'(valid_m), 32'd1);
      consume(200, 1'b0);

      // Order above N_MAX on the N_MAX=5 instance
      sel_b = 1'b1;
      push_model(16'h0800, 5);
      do_start(16'h0800, 4'd7);
      consume(200, 1'b1);
      sel_b = 1'b0;

      // Asynchronous reset mid-COMPUTE
      do_start(16'h0800, 4'd4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("pre_rst_compute", 32'(valid_m), 32'd0);
      #2 rst = 1'b1;
      #1 chk_zero("rst_compute");
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-EMIT, then restart with a new x
      do_start(16'h2000, 4'd3);
      #2 rst = 1'b1;
      #1 chk_zero("rst_emit");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push_model(16'hF000, 3);
      do_start(16'hF000, 4'd3);
      consume(200, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
